// File: rtl/ram_arbiter_if.sv
// Requester-side and RAM-side signal bundle for the two-port RAM arbiter.
interface ram_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 8
);
  logic          req0, req1;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1;
  logic          rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          busy;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_wr, ram_rd;
  logic [DW-1:0] ram_dout;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dout,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, busy,
           ram_addr, ram_din, ram_wr, ram_rd
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dout,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, busy,
           ram_addr, ram_din, ram_wr, ram_rd
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter serialising two single-byte requesters onto one
// single-port RAM; every output comes straight from a flop.
module ram_arbiter #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic         clk,
  input  logic         rst,
  ram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          port_q, port_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic          wr_q, wr_d, rd_q, rd_d;
  logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic          busy_q, busy_d;
  logic          sel, sel_we;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    port_d    = port_q;
    addr_d    = addr_q;
    din_d     = din_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    wr_d      = 1'b0;
    rd_d      = 1'b0;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    busy_d    = 1'b0;
    // On a tie the port that did not win last time goes first.
    sel    = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
    sel_we = sel ? bus.we1 : bus.we0;

    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          port_d = sel;
          last_d = sel;
          addr_d = sel ? bus.addr1 : bus.addr0;
          din_d  = sel_we ? (sel ? bus.wdata1 : bus.wdata0) : '0;
          gnt0_d = ~sel;
          gnt1_d = sel;
          busy_d = 1'b1;
          if (sel_we) begin
            state_d = WRITE;
            wr_d    = 1'b1;
          end else begin
            state_d = READ;
            rd_d    = 1'b1;
          end
        end
      end
      WRITE: state_d = IDLE;
      READ: begin
        // RAM output is combinational while rd is high; capture it at the closing edge.
        state_d = IDLE;
        if (port_q) begin
          rdata1_d  = bus.ram_dout;
          rvalid1_d = 1'b1;
        end else begin
          rdata0_d  = bus.ram_dout;
          rvalid0_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      port_q    <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      port_q    <= port_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.gnt0     = gnt0_q;
  assign bus.gnt1     = gnt1_q;
  assign bus.rvalid0  = rvalid0_q;
  assign bus.rvalid1  = rvalid1_q;
  assign bus.rdata0   = rdata0_q;
  assign bus.rdata1   = rdata1_q;
  assign bus.busy     = busy_q;
  assign bus.ram_addr = addr_q;
  assign bus.ram_din  = din_q;
  assign bus.ram_wr   = wr_q;
  assign bus.ram_rd   = rd_q;
endmodule
